// File: rtl/piso.sv
// Parallel-in, serial-out shift register: captures a WIDTH-bit word, emits it MSB-first on q.
// Latency: d[WIDTH-1] on q right after the load edge; d[WIDTH-1-k] after the k-th shift edge.
// Backpressure: none. Every edge either loads or shifts, so the consumer must take one bit per clock.
//
// Ports:
//   d       parallel word, sampled on an edge with sl = 0
//   clk     rising-edge clock
//   sl      shift/load control: 0 = load d, 1 = shift
//   q       serial data out, always shreg[WIDTH-1]
//   rst_n   asynchronous active-low reset (clears word and bit count)
//   q_valid high while q carries a not-yet-sent data bit
module piso #(
    parameter int   WIDTH = 4,
    parameter logic FILL  = 1'b0
) (
    input  logic [WIDTH-1:0] d,
    input  logic             clk,
    input  logic             sl,
    output logic             q,
    input  logic             rst_n,
    output logic             q_valid
);

    localparam int             CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  CNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    logic [WIDTH-1:0] shreg;
    // Data bits still to be presented on q, including the one currently there.
    logic [CW-1:0]    cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (!sl) begin
            // A load always wins, discarding whatever was still in flight.
            shreg <= d;
            cnt   <= CNT_FULL;
        end else begin
            shreg <= {shreg[WIDTH-2:0], FILL};
            // Saturate so over-shifting keeps q_valid low while fill streams out.
            if (cnt != '0) begin
                cnt <= cnt - CNT_ONE;
            end
        end
    end

    // Outputs come straight from registers; no path from d or sl.
    assign q       = shreg[WIDTH-1];
    assign q_valid = (cnt != '0);

endmodule

// File: tb/tb_piso.sv
module tb_piso;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] d4;
    logic       sl4;
    logic       q4, v4;
    logic [7:0] d8;
    logic       sl8;
    logic       q8, v8;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: the word last loaded and how many shifts have happened since.
    logic [31:0] m4_word, m8_word;
    int          m4_k, m8_k;
    bit          m4_ld, m8_ld;

    always #5 clk = ~clk;

    piso #(.WIDTH(4), .FILL(1'b0)) u_p4 (
        .d(d4), .clk(clk), .sl(sl4), .q(q4), .rst_n(rst_n), .q_valid(v4)
    );

    piso #(.WIDTH(8), .FILL(1'b1)) u_p8 (
        .d(d8), .clk(clk), .sl(sl8), .q(q8), .rst_n(rst_n), .q_valid(v8)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // Bit k of the serial stream: word bits MSB-first, then fill forever.
    function automatic logic model_q(input logic [31:0] word, input int k, input int w, input logic fill);
        if (k < w) return word[w-1-k];
        return fill;
    endfunction

    function automatic logic model_v(input bit ld, input int k, input int w);
        return ld && (k < w);
    endfunction

    task automatic model_reset();
        m4_word = '0; m4_k = 0; m4_ld = 1'b0;
        m8_word = '0; m8_k = 0; m8_ld = 1'b0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".q4"}, {31'd0, q4}, {31'd0, model_q(m4_word, m4_k, 4, 1'b0)});
        chk({tag, ".v4"}, {31'd0, v4}, {31'd0, model_v(m4_ld, m4_k, 4)});
        chk({tag, ".q8"}, {31'd0, q8}, {31'd0, model_q(m8_word, m8_k, 8, 1'b1)});
        chk({tag, ".v8"}, {31'd0, v8}, {31'd0, model_v(m8_ld, m8_k, 8)});
    endtask

    // Drive both instances for one clock edge, advance the model, check #1 after the edge.
    task automatic step(input logic s4, input logic [3:0] dd4,
                        input logic s8, input logic [7:0] dd8, input string tag);
        sl4 = s4; d4 = dd4; sl8 = s8; d8 = dd8;
        @(posedge clk);
        if (!s4) begin m4_word = {28'd0, dd4}; m4_k = 0; m4_ld = 1'b1; end
        else if (m4_k < 1000) m4_k++;
        if (!s8) begin m8_word = {24'd0, dd8}; m8_k = 0; m8_ld = 1'b1; end
        else if (m8_k < 1000) m8_k++;
        #1;
        check_all(tag);
    endtask

    task automatic step4(input logic s4, input logic [3:0] dd4, input string tag);
        step(s4, dd4, 1'b1, 8'($urandom), tag);
    endtask

    // Assert reset away from any edge, confirm outputs clear with no clock, then release.
    task automatic async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all({tag, ".async"});
        @(posedge clk);
        #1;
        check_all({tag, ".held"});
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] w;
        logic [7:0] a5;
        logic [3:0] seq;
        rst_n = 1'b0;
        sl4 = 1'b1; d4 = '0; sl8 = 1'b1; d8 = '0;
        model_reset();
        #1;
        chk("reset.q4", {31'd0, q4}, 32'd0);
        chk("reset.v4", {31'd0, v4}, 32'd0);
        check_all("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Reset mid-word, then a shift must not revive anything.
        step4(1'b0, 4'b1011, "pre_rst_load");
        async_reset("midword");
        chk("rst.q4", {31'd0, q4}, 32'd0);
        chk("rst.v4", {31'd0, v4}, 32'd0);
        step4(1'b1, 4'b1111, "post_rst_shift");
        chk("post_rst.q4", {31'd0, q4}, 32'd0);
        chk("post_rst.v4", {31'd0, v4}, 32'd0);

        // Load then shift.
        step4(1'b0, 4'b1011, "ls_load");
        chk("ls_load.q4", {31'd0, q4}, 32'd1);
        chk("ls_load.v4", {31'd0, v4}, 32'd1);
        seq = 4'b0110;  // expected q after shifts 1..3, MSB first in seq[3:1]
        for (int i = 0; i < 3; i++) begin
            step4(1'b1, 4'($urandom), "ls_shift");
            chk($sformatf("ls_shift%0d.q4", i), {31'd0, q4}, {31'd0, seq[3-i]});
            chk($sformatf("ls_shift%0d.v4", i), {31'd0, v4}, 32'd1);
        end
        step4(1'b0, 4'b0000, "ls_reload0");
        chk("ls_reload0.q4", {31'd0, q4}, 32'd0);
        chk("ls_reload0.v4", {31'd0, v4}, 32'd1);

        // Over-shift past the end of the word.
        step4(1'b0, 4'b1001, "os_load");
        chk("os_load.q4", {31'd0, q4}, 32'd1);
        for (int i = 0; i < 3; i++) step4(1'b1, 4'($urandom), "os_shift");
        chk("os_last.q4", {31'd0, q4}, 32'd1);
        chk("os_last.v4", {31'd0, v4}, 32'd1);
        step4(1'b1, 4'($urandom), "os_shift4");
        chk("os_fill.q4", {31'd0, q4}, 32'd0);
        chk("os_fill.v4", {31'd0, v4}, 32'd0);
        step4(1'b1, 4'($urandom), "os_shift5");
        chk("os_sat.v4", {31'd0, v4}, 32'd0);

        // Reload mid-word.
        step4(1'b0, 4'b1100, "rl_load");
        step4(1'b1, 4'($urandom), "rl_shift");
        chk("rl_shift.q4", {31'd0, q4}, 32'd1);
        step4(1'b0, 4'b0111, "rl_reload");
        chk("rl_reload.q4", {31'd0, q4}, 32'd0);
        chk("rl_reload.v4", {31'd0, v4}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            step4(1'b1, 4'($urandom), "rl_tail");
            chk($sformatf("rl_tail%0d.q4", i), {31'd0, q4}, 32'd1);
            chk($sformatf("rl_tail%0d.v4", i), {31'd0, v4}, 32'd1);
        end

        // Continuous load.
        step4(1'b0, 4'b1000, "cl0");
        chk("cl0.q4", {31'd0, q4}, 32'd1);
        step4(1'b0, 4'b0111, "cl1");
        chk("cl1.q4", {31'd0, q4}, 32'd0);
        step4(1'b0, 4'b1111, "cl2");
        chk("cl2.q4", {31'd0, q4}, 32'd1);
        chk("cl2.v4", {31'd0, v4}, 32'd1);

        // Wide instance with FILL = 1.
        a5 = 8'hA5;
        step(1'b1, 4'($urandom), 1'b0, a5, "w8_load");
        chk("w8_load.q8", {31'd0, q8}, {31'd0, a5[7]});
        for (int i = 1; i < 8; i++) begin
            step(1'b1, 4'($urandom), 1'b1, 8'($urandom), "w8_shift");
            chk($sformatf("w8_shift%0d.q8", i), {31'd0, q8}, {31'd0, a5[7-i]});
            chk($sformatf("w8_shift%0d.v8", i), {31'd0, v8}, 32'd1);
        end
        step(1'b1, 4'($urandom), 1'b1, 8'($urandom), "w8_fill");
        chk("w8_fill.q8", {31'd0, q8}, 32'd1);
        chk("w8_fill.v8", {31'd0, v8}, 32'd0);

        // Random traffic, shift-biased so words frequently drain and over-shift.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                async_reset("rnd_rst");
            end else begin
                w = 4'($urandom);
                step(1'($urandom_range(0, 3) != 0), w,
                     1'($urandom_range(0, 5) != 0), 8'($urandom), "rnd");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
